// File: rtl/ov7670_capture.sv
// OV7670 frame capture: RGB565 byte pairs -> RGB332 buffer writes at y*WIDTH+x, with frame/line status.
// Optional build macro CAPTURE_TEST_PATTERN_EN replaces pixel data with a red/blue split pattern.
module ov7670_capture #(
   parameter int WIDTH  = 176,
   parameter int HEIGHT = 144,
   parameter int ADDR_W = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              VSYNC,
   input  logic              HREF,
   input  logic [7:0]        DATA,
   output logic [7:0]        PIXEL_OUT,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic              W_EN,
   output logic              FRAME_DONE,
   output logic [7:0]        FRAME_LINES,
   output logic              LINE_ERR,
   output logic [1:0]        state_dbg
);

   localparam int XW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      VBLANK = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic              frame_start, frame_end;
   logic              byte_en, line_end;
   logic              href_q;
   logic              phase;
   logic [7:0]        hi;
   logic [XW-1:0]     x;
   logic [7:0]        line_cnt;
   logic [ADDR_W-1:0] line_base;
   logic              x_in, row_in;
   logic [7:0]        pix;

   assign state_dbg = state;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= SYNC;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         SYNC:   if (VSYNC) state_nxt = VBLANK;
         VBLANK: if (!VSYNC) begin
            state_nxt   = ACTIVE;
            frame_start = 1'b1;
         end
         ACTIVE: if (VSYNC) begin
            state_nxt = VBLANK;
            frame_end = 1'b1;
         end
         default: state_nxt = SYNC;
      endcase
   end

   // A VSYNC rise on the same edge as a byte or an HREF fall takes priority over both.
   assign byte_en  = (state == ACTIVE) && !VSYNC && HREF;
   assign line_end = (state == ACTIVE) && !VSYNC && !HREF && href_q;
   assign x_in     = int'(x) < WIDTH;
   assign row_in   = int'(line_cnt) < HEIGHT;

`ifdef CAPTURE_TEST_PATTERN_EN
   assign pix = (int'(x) < WIDTH / 2) ? 8'b111_000_00 : 8'b000_000_11;
`else
   assign pix = {hi[7:5], hi[2:0], DATA[4:3]};
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         href_q      <= 1'b0;
         phase       <= 1'b0;
         hi          <= '0;
         x           <= '0;
         line_cnt    <= '0;
         line_base   <= '0;
         PIXEL_OUT   <= '0;
         W_ADDR      <= '0;
         W_EN        <= 1'b0;
         FRAME_DONE  <= 1'b0;
         FRAME_LINES <= '0;
         LINE_ERR    <= 1'b0;
      end else begin
         href_q     <= HREF;
         W_EN       <= 1'b0;
         FRAME_DONE <= 1'b0;

         if (frame_start) begin
            x         <= '0;
            line_base <= '0;
            line_cnt  <= '0;
            phase     <= 1'b0;
            LINE_ERR  <= 1'b0;
         end

         // line_cnt already saturates at 255, so it is the clamped count
         if (frame_end) begin
            FRAME_DONE  <= 1'b1;
            FRAME_LINES <= line_cnt;
            phase       <= 1'b0;
         end

         if (byte_en) begin
            phase <= ~phase;
            if (!phase) begin
               hi <= DATA;
            end else begin
               if (x_in && row_in) begin
                  W_EN      <= 1'b1;
                  W_ADDR    <= line_base + ADDR_W'(x);
                  PIXEL_OUT <= pix;
               end
               if (x_in) x <= x + 1'b1;
            end
         end

         if (line_end) begin
            x <= '0;
            if (line_cnt != 8'hFF) line_cnt <= line_cnt + 8'd1;
            if (row_in) line_base <= line_base + ADDR_W'(WIDTH);
            if (phase) begin
               LINE_ERR <= 1'b1;
               phase    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized bench for ov7670_capture: a frame-level model pushes expected writes and
// frame reports into queues; a negedge monitor pops and compares whatever the DUT emits.
module tb_ov7670_capture;

   localparam int WIDTH  = 176;
   localparam int HEIGHT = 144;
   localparam int ADDR_W = 15;
   localparam int EW     = ADDR_W + 8;

   logic              CLK = 1'b0;
   logic              RESET = 1'b1;
   logic              VSYNC = 1'b0;
   logic              HREF = 1'b0;
   logic [7:0]        DATA = 8'h00;
   logic [7:0]        PIXEL_OUT;
   logic [ADDR_W-1:0] W_ADDR;
   logic              W_EN;
   logic              FRAME_DONE;
   logic [7:0]        FRAME_LINES;
   logic              LINE_ERR;
   logic [1:0]        state_dbg;

   ov7670_capture #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RESET(RESET), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
      .PIXEL_OUT(PIXEL_OUT), .W_ADDR(W_ADDR), .W_EN(W_EN),
      .FRAME_DONE(FRAME_DONE), .FRAME_LINES(FRAME_LINES), .LINE_ERR(LINE_ERR),
      .state_dbg(state_dbg)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [8:0]    frm_q[$];
   int lines;
   bit err;
   bit live = 1'b0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [7:0]        last_pix = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] ref_pixel(input int p, input logic [7:0] hi, input logic [7:0] d);
      int v;
`ifdef CAPTURE_TEST_PATTERN_EN
      v = (p < WIDTH / 2) ? 224 : 3;
      if (hi === 8'hxx && d === 8'hxx) v = 0;
`else
      v = ((hi >> 5) & 7) * 32 + (hi & 7) * 4 + ((d >> 3) & 3);
      if (p < 0) v = 0;
`endif
      return 8'(v);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_frame();
      VSYNC = 1'b1;
      for (int i = 0; i < 6; i++) begin
         HREF = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
         DATA = 8'($urandom);
         tick();
      end
      VSYNC = 1'b0;
      HREF  = 1'b0;
      live  = 1'b1;
      lines = 0;
      err   = 1'b0;
      tick();
      tick();
      check("line_err_clear", {31'd0, LINE_ERR}, 32'd0);
   endtask

   task automatic end_frame(input bit href_hold);
      VSYNC = 1'b1;
      HREF  = href_hold;
      if (live) frm_q.push_back({err, 8'((lines > 255) ? 255 : lines)});
      tick();
      HREF = 1'b0;
      repeat (4) tick();
   endtask

   // abort_at in [0, nbytes] raises VSYNC on that byte slot (nbytes = the HREF-fall edge)
   task automatic drive_line(input int nbytes, input int abort_at, input bit fixed, input int gap);
      logic [7:0] hi, d;
      int p;
      hi = 8'h00;
      for (int b = 0; b <= nbytes; b++) begin
         if (b == abort_at) begin
            end_frame(b < nbytes);
            return;
         end
         if (b == nbytes) break;
         d = fixed ? ((b % 2 == 0) ? 8'hF8 : 8'h1F) : 8'($urandom);
         HREF = 1'b1;
         DATA = d;
         if (b % 2 == 0) hi = d;
         else begin
            p = b / 2;
            if (live && p < WIDTH && lines < HEIGHT)
               exp_q.push_back({ADDR_W'(lines * WIDTH + p), ref_pixel(p, hi, d)});
         end
         tick();
      end
      HREF = 1'b0;
      DATA = 8'($urandom);
      if (lines < 255) lines++;
      if (nbytes % 2 == 1) err = 1'b1;
      tick();
      repeat (gap) tick();
   endtask

   always @(negedge CLK) begin
      logic [EW-1:0] e;
      logic [8:0]    f;
      if (RESET) begin
         last_addr = '0;
         last_pix  = '0;
      end else begin
         if (W_EN) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual addr=%0d pix=%0h required no write", W_ADDR, PIXEL_OUT);
               last_addr = W_ADDR;
               last_pix  = PIXEL_OUT;
            end else begin
               e = exp_q.pop_front();
               check("write_addr_pix", 32'({W_ADDR, PIXEL_OUT}), 32'(e));
               last_addr = e[EW-1:8];
               last_pix  = e[7:0];
            end
         end else begin
            check("hold_addr_pix", 32'({W_ADDR, PIXEL_OUT}), 32'({last_addr, last_pix}));
         end
         if (FRAME_DONE) begin
            if (frm_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame_done actual lines=%0d required none", FRAME_LINES);
            end else begin
               f = frm_q.pop_front();
               check("frame_err_lines", 32'({LINE_ERR, FRAME_LINES}), 32'(f));
            end
         end
      end
   end

   initial begin
      repeat (4) tick();
      check("rst_w_en",        {31'd0, W_EN}, 32'd0);
      check("rst_frame_done",  {31'd0, FRAME_DONE}, 32'd0);
      check("rst_pixel",       32'(PIXEL_OUT), 32'd0);
      check("rst_addr",        32'(W_ADDR), 32'd0);
      check("rst_frame_lines", 32'(FRAME_LINES), 32'd0);
      check("rst_line_err",    {31'd0, LINE_ERR}, 32'd0);

      // startup alignment: mid-frame traffic before any VSYNC must not write
      RESET = 1'b0;
      for (int i = 0; i < 60; i++) begin
         HREF = 1'($urandom_range(0, 1));
         DATA = 8'($urandom);
         tick();
      end
      HREF = 1'b0;

      start_frame();
      for (int l = 0; l < 2; l++) drive_line(352, -1, 1'b1, 4);
      end_frame(1'b0);

      start_frame();
      for (int l = 0; l < 150; l++) drive_line(400, -1, 1'b0, 3);
      end_frame(1'b0);

      start_frame();
      drive_line(351, -1, 1'b0, 4);
      drive_line(352, -1, 1'b0, 4);
      end_frame(1'b0);

      start_frame();
      for (int l = 0; l < 3; l++) drive_line(352, -1, 1'b0, 4);
      drive_line(352, 101, 1'b0, 4);

      start_frame();
      drive_line(352, -1, 1'b0, 4);
      drive_line(352, 352, 1'b0, 4);

      for (int fr = 0; fr < 3; fr++) begin
         int nl;
         nl = $urandom_range(1, 5);
         start_frame();
         for (int l = 0; l < nl; l++) drive_line($urandom_range(2, 380), -1, 1'b0, $urandom_range(1, 6));
         end_frame(1'b0);
      end

      // asynchronous reset in mid-line: outputs clear at once, rest of the frame is dropped
      start_frame();
      drive_line(200, -1, 1'b0, 4);
      fork
         drive_line(352, -1, 1'b0, 4);
         begin
            repeat (120) @(posedge CLK);
            #3;
            RESET = 1'b1;
            #1;
            check("mid_rst_w_en",        {31'd0, W_EN}, 32'd0);
            check("mid_rst_frame_done",  {31'd0, FRAME_DONE}, 32'd0);
            check("mid_rst_pixel",       32'(PIXEL_OUT), 32'd0);
            check("mid_rst_addr",        32'(W_ADDR), 32'd0);
            check("mid_rst_frame_lines", 32'(FRAME_LINES), 32'd0);
            check("mid_rst_line_err",    {31'd0, LINE_ERR}, 32'd0);
            exp_q.delete();
            live = 1'b0;
            repeat (3) @(posedge CLK);
            #3;
            RESET = 1'b0;
         end
      join

      start_frame();
      drive_line(352, -1, 1'b0, 4);
      end_frame(1'b0);

      repeat (10) tick();
      check("exp_queue_drained",   32'(exp_q.size()), 32'd0);
      check("frame_queue_drained", 32'(frm_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Frame capture stage between the OV7670 camera bus and the dual-port M9K frame buffer. Clocked directly by the camera pixel clock, it samples VSYNC/HREF/8-bit data, assembles each two-byte RGB565 pixel into RGB332, and issues one buffer write per pixel with a linear address for a 176x144 buffer. It also reports frame completion, the number of lines captured and odd-byte line errors for the downstream image processor.

## Interface
- `WIDTH`, 176, pixels per buffer line.
- `HEIGHT`, 144, lines per buffer frame.
- `ADDR_W`, 15, write-address width.
- `CLK`  in  1  camera PCLK; all logic is on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `VSYNC`  in  1  camera frame sync; high means vertical blank.
- `HREF`  in  1  camera line-valid signal.
- `DATA`  in  8  camera byte, already in bit order D7..D0.
- `PIXEL_OUT`  out  8  RGB332 pixel for the buffer.
- `W_ADDR`  out  ADDR_W  buffer write address, y*WIDTH + x.
- `W_EN`  out  1  one-cycle write strobe.
- `FRAME_DONE`  out  1  one-cycle pulse at the end of a captured frame.
- `FRAME_LINES`  out  8  lines seen in the last completed frame; latched at FRAME_DONE.
- `LINE_ERR`  out  1  sticky for the current frame; set when a line ends on an odd byte count.

## Operation
- **Reset:** every output is 0, and all internal registers are 0. The state is SYNC.
- **State machine:**
  - SYNC to VBLANK when VSYNC=1. This discards the partial frame that was in progress at reset.
  - VBLANK to ACTIVE when VSYNC=0. On entry: x=0, line_base=0, line count=0, phase=0, LINE_ERR=0.
  - ACTIVE to VBLANK when VSYNC=1. This drives a FRAME_DONE pulse and latches FRAME_LINES = min(line count, 255).
- **Byte capture:** bytes are captured only in ACTIVE with HREF=1.
  - With phase=0, the byte is stored as hi.
  - With phase=1, pixel = {hi[7:5], hi[2:0], DATA[4:3]}.
  - phase toggles on every captured byte.
- **Pixel write:** on the second byte, W_EN=1 only if x<WIDTH and the line count is less than HEIGHT.
  - W_ADDR = line_base + x.
  - x then increments, saturating at WIDTH.
- **End of line:** detected on the HREF falling edge, using a registered copy of HREF.
  - x=0.
  - Line count increments, saturating at 255.
  - line_base += WIDTH, but only while the line count is less than HEIGHT. No multiplier is used.
  - If phase=1, LINE_ERR is set and phase returns to 0.
- **Blanking:** HREF is ignored in SYNC and VBLANK.
- **VSYNC rising mid-line:** any partial byte is dropped, with no write. FRAME_DONE still pulses. The unfinished line is not counted.
- **Outside the buffer:** pixels beyond WIDTH or HEIGHT are consumed but not written.

## Timing
- Pixel latency: PIXEL_OUT, W_ADDR and W_EN are registered. They are valid in the cycle after the edge that samples the second byte.
- W_EN is high for exactly one cycle per pixel. PIXEL_OUT and W_ADDR hold their values until the next write.
- FRAME_DONE is high for the one cycle after the edge that first samples VSYNC=1 in ACTIVE.
- FRAME_LINES updates in the same cycle as FRAME_DONE.
- End-of-line detection takes one cycle, at the first edge where HREF=0 and the registered copy is 1.
- An HREF falling edge and a VSYNC rise on the same edge: VSYNC wins, and the line is not counted.
- An asynchronous reset in mid-frame returns the block to SYNC. The rest of that frame produces no writes.

## Configuration
- `CAPTURE_TEST_PATTERN_EN`
- **Defined:** PIXEL_OUT is replaced by a test pattern and DATA is ignored.
  - 8'b111_000_00 (red) when x<WIDTH/2, otherwise 8'b000_000_11 (blue).
  - W_EN, W_ADDR, the FSM and all status outputs behave exactly as in normal operation. This exercises the buffer and the red/blue counters without a camera.
- **Undefined:** PIXEL_OUT carries the converted camera data.

## Test plan
- **Reset, then one frame:** reset; VSYNC 1 then 0; 2 lines of 352 bytes with bytes 0xF8, 0x1F repeated.
  - Expect 352 W_EN pulses, W_ADDR 0..351, PIXEL_OUT = 0xE3.
  - On VSYNC rise: FRAME_DONE pulse, FRAME_LINES=2.
- **Oversize frame:** 150 lines of 400 bytes.
  - Expect exactly 176 writes per line for the first 144 lines, last W_ADDR=25343, no writes for lines 144..149.
  - FRAME_LINES=150.
- **Odd line:** one line of 351 bytes, then a normal line.
  - Expect 175 writes on line 0, LINE_ERR=1, line 1 starting at W_ADDR 176 with a correctly paired first pixel.
  - LINE_ERR clears at the next frame start.
- **Startup alignment:** release reset with VSYNC=0 and HREF toggling.
  - Expect no W_EN until VSYNC has gone 1 then 0.
- **VSYNC rises at byte 101 of line 3:**
  - Expect 50 writes on that line, FRAME_DONE pulse, FRAME_LINES=3.
  - Asserting RESET mid-line instead forces all outputs to 0 immediately.
- **Test pattern:** with `CAPTURE_TEST_PATTERN_EN` defined, one full frame.
  - Expect PIXEL_OUT=0xE0 for x 0..87 and 0x03 for x 88..175 on every line.
